// File: rtl/cla_slice_seq_ctrl.sv
// cla_slice_seq_ctrl
//   Time-multiplexes one external, purely combinational 4-bit carry-lookahead slice to add
//   WIDTH-bit words. Operands arrive over a valid/ready handshake. The slice is driven one
//   nibble per cycle, LSB first, with the slice carry rippled through a register between cycles.
//   The sum, carry-out and word-level propagate/generate are returned over a valid/ready handshake.
//
// Parameters
//   WIDTH      operand width, multiple of 4 and >= 8 (NSLICE = WIDTH/4 slice cycles per add)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a, b, ci are latched on acceptance
//   out_valid/out_ready   result handshake; s, co, p_all, g_all held while out_valid
//   sl_a, sl_b, sl_c0     drive to the shared slice (zero outside the run phase)
//   sl_s, sl_c, sl_p, sl_g  slice results, sampled in the cycle they are driven
//   ovf                   signed overflow of the last add (only when CLA_SEQ_OVF_EN is defined)
//
// Configuration
//   CLA_SEQ_OVF_EN        when defined, adds the ovf output and its register

module cla_slice_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             p_all,
  output logic             g_all,
  output logic [3:0]       sl_a,
  output logic [3:0]       sl_b,
  output logic             sl_c0,
  input  logic [3:0]       sl_s,
  input  logic [3:0]       sl_c,
  input  logic             sl_p,
`ifdef CLA_SEQ_OVF_EN
  input  logic             sl_g,
  output logic             ovf
`else
  input  logic             sl_g
`endif
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, p_q, g_q;
  logic [IDXW+1:0]  bit_base;
  logic             accept;
  logic             last_slice;

  assign bit_base   = {idx_q, 2'b00};
  assign accept     = in_valid && in_ready;
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    // in_ready is gated by rst_n so it stays low for the whole time reset is asserted.
    in_ready  = (state_q == StIdle) && rst_n;
    out_valid = (state_q == StDone);
    sl_a      = 4'h0;
    sl_b      = 4'h0;
    sl_c0     = 1'b0;
    if (state_q == StRun) begin
      sl_a  = a_q[bit_base +: 4];
      sl_b  = b_q[bit_base +: 4];
      sl_c0 = carry_q;
    end
  end

  // Datapath: operand capture and per-slice accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            idx_q   <= '0;
            p_q     <= 1'b1;
            g_q     <= 1'b0;
          end
        end
        StRun: begin
          s_q[bit_base +: 4] <= sl_s;
          carry_q            <= sl_c[3];
          p_q                <= p_q & sl_p;
          // Higher slice folds over the accumulated lower group: G = G_hi | P_hi & G_lo.
          g_q                <= sl_g | (sl_p & g_q);
          idx_q              <= last_slice ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it, on the top slice only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last_slice) begin
      ovf_q <= sl_c[3] ^ sl_c[2];
    end
  end

  assign ovf = ovf_q;

  logic unused_sl_c;
  assign unused_sl_c = ^sl_c[1:0];
`else
  logic unused_sl_c;
  assign unused_sl_c = ^sl_c[2:0];
`endif

  assign s     = s_q;
  assign co    = carry_q;
  assign p_all = p_q;
  assign g_all = g_q;

endmodule

// File: tb/tb_cla_slice_seq_ctrl.sv
// tb_cla_slice_seq_ctrl
//   Self-checking bench for cla_slice_seq_ctrl (WIDTH=16). Provides a behavioural 4-bit slice,
//   and compares every result with word-level arithmetic: {co,s} = a+b+ci, p_all = &(a^b),
//   g_all = carry out of a+b with zero carry-in. Honours CLA_SEQ_OVF_EN for the ovf output.

module tb_cla_slice_seq_ctrl;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          ci;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          co, p_all, g_all;
  logic [3:0]    sl_a, sl_b, sl_s, sl_c;
  logic          sl_c0, sl_p, sl_g;
`ifdef CLA_SEQ_OVF_EN
  logic          ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_slice_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .p_all     (p_all),
    .g_all     (g_all),
    .sl_a      (sl_a),
    .sl_b      (sl_b),
    .sl_c0     (sl_c0),
    .sl_s      (sl_s),
    .sl_c      (sl_c),
    .sl_p      (sl_p),
`ifdef CLA_SEQ_OVF_EN
    .sl_g      (sl_g),
    .ovf       (ovf)
`else
    .sl_g      (sl_g)
`endif
  );

  // Behavioural combinational 4-bit CLA slice.
  always_comb begin
    logic c;
    c = sl_c0;
    for (int i = 0; i < 4; i++) begin
      sl_s[i] = sl_a[i] ^ sl_b[i] ^ c;
      c       = (sl_a[i] & sl_b[i]) | (c & (sl_a[i] ^ sl_b[i]));
      sl_c[i] = c;
    end
    sl_p = &(sl_a ^ sl_b);
    sl_g = ((5'(sl_a) + 5'(sl_b)) >= 5'd16);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(n < 20), 32'd1);
  endtask

  // One add with 'hold' cycles of backpressure in the result phase.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                        input int hold);
    logic [W:0] sum, sum0;
    logic       ep, eg, eovf;
    int         lat;
    sum  = {1'b0, oa} + {1'b0, ob} + (W+1)'(oci);
    sum0 = {1'b0, oa} + {1'b0, ob};
    ep   = &(oa ^ ob);
    eg   = sum0[W];
    eovf = (oa[W-1] == ob[W-1]) && (sum[W-1] != oa[W-1]);
    wait_ready();
    a = oa; b = ob; ci = oci; in_valid = 1'b1; out_ready = (hold == 0);
    tick();  // accepting edge
    in_valid = 1'b0;
    // Operands are free to change once accepted.
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("run_in_ready", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    // Counting the accepting edge as the first, out_valid follows the (NSLICE+1)th edge.
    check("latency", 32'(lat + 1), 32'(NSLICE + 1));
    check("sum", 32'(s), 32'(sum[W-1:0]));
    check("co", 32'(co), 32'(sum[W]));
    check("p_all", 32'(p_all), 32'(ep));
    check("g_all", 32'(g_all), 32'(eg));
`ifdef CLA_SEQ_OVF_EN
    check("ovf", 32'(ovf), 32'(eovf));
`else
    if (eovf) total = total + 0;
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;  // must be ignored while a result is pending
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(s), 32'(sum[W-1:0]));
      check("hold_co", 32'(co), 32'(sum[W]));
      check("hold_g", 32'(g_all), 32'(eg));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("retain_sum", 32'(s), 32'(sum[W-1:0]));
  endtask

  initial begin
    logic [W-1:0] ta, tb;
    logic         tci;
    logic [W:0]   esum;
    int           acc, prev;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_flags", 32'({co, p_all, g_all}), 32'd0);
    check("rst_sl_a", 32'({sl_a, sl_b, sl_c0}), 32'd0);
    #5 rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 10);

    // Reset asserted mid-run with idx=2.
    wait_ready();
    a = 16'hABCD; b = 16'h1111; ci = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_run_sl_a", 32'(sl_a), 32'hB);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_flags", 32'({co, p_all, g_all}), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_slice", 32'({sl_a, sl_b, sl_c0}), 32'd0);
    tick();
    check("midrst_hold_valid", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 0);

`ifdef CLA_SEQ_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
`endif

    for (int k = 0; k < 6; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Continuous requests without backpressure: one accept every NSLICE+2 cycles.
    out_ready = 1'b1;
    ta = W'($urandom); tb = W'($urandom); tci = 1'($urandom);
    a = ta; b = tb; ci = tci; in_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      int n;
      wait_ready();
      esum = {1'b0, ta} + {1'b0, tb} + (W+1)'(tci);
      acc  = cyc;
      tick();
      if (k > 0) check("interval", 32'(acc - prev), 32'(NSLICE + 2));
      prev = acc;
      ta = W'($urandom); tb = W'($urandom); tci = 1'($urandom);
      a = ta; b = tb; ci = tci;
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check("stream_timeout", 32'(n < 20), 32'd1);
      check("stream_sum", 32'(s), 32'(esum[W-1:0]));
      check("stream_co", 32'(co), 32'(esum[W]));
    end
    in_valid = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
